// File: rtl/vram_bus_responder.sv
// vram_bus_responder
// Responder for the VRAM strobe/ack fetch protocol. Arbitrates the CPU port and
// three display fetch ports (layer0, layer1, sprite) onto a single-ported 32-bit
// VRAM. Each access completes as a one-cycle ack exactly RAM_LATENCY cycles after
// it was issued, with read data valid in the ack cycle.
// RAM_LATENCY is meant to be 1..3. The slot pipeline below is RAM_LATENCY deep, so
// a port's pending bit stays set for exactly the lifetime of its access.
module vram_bus_responder #(
    parameter int ADDR_W      = 15,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    // CPU access port
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wrdata_i,
    input  logic [3:0]        cpu_wrbytesel_i,
    input  logic              cpu_write_i,
    input  logic              cpu_strobe_i,
    output logic [31:0]       cpu_rddata_o,
    output logic              cpu_ack_o,

    // Display fetch ports
    input  logic [ADDR_W-1:0] l0_addr_i,
    input  logic              l0_strobe_i,
    output logic              l0_ack_o,
    input  logic [ADDR_W-1:0] l1_addr_i,
    input  logic              l1_strobe_i,
    output logic              l1_ack_o,
    input  logic [ADDR_W-1:0] spr_addr_i,
    input  logic              spr_strobe_i,
    output logic              spr_ack_o,
    output logic [31:0]       bus_rddata_o,

    // VRAM macro side
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [31:0]       vram_wrdata_o,
    output logic [3:0]        vram_wrbytesel_o,
    output logic              vram_write_o,
    output logic              vram_en_o,
    input  logic [31:0]       vram_rddata_i
);

    // Port indices, also the bit positions in the per-port vectors.
    localparam logic [1:0] PORT_CPU = 2'd0;
    localparam logic [1:0] PORT_L0  = 2'd1;
    localparam logic [1:0] PORT_L1  = 2'd2;
    localparam logic [1:0] PORT_SPR = 2'd3;

    // One in-flight access: which port it belongs to and whether it was a CPU write.
    typedef struct packed {
        logic       valid;
        logic [1:0] port;
        logic       isWrite;
    } slot_t;

    slot_t       pipe_q [RAM_LATENCY];
    slot_t       issueSlot;
    slot_t       retireSlot;

    logic [3:0]  strobeVec;
    logic [3:0]  ackVec;
    logic [3:0]  eligible;
    logic [3:0]  grantVec;
    logic        grantValid;
    logic [1:0]  grantPort;

    logic [3:0]  pending_q;
    logic [3:0]  pending_d;
    logic [31:0] cpuRdData_q;
    logic [31:0] cpuRdData_d;
    logic [31:0] busRdData_q;
    logic [31:0] busRdData_d;

    // The oldest slot retires in the cycle its RAM data is valid.
    assign retireSlot = pipe_q[RAM_LATENCY-1];

    // Decode the retiring slot into the per-port ack vector (at most one bit set).
    always_comb begin
        ackVec = 4'b0000;
        if (retireSlot.valid) begin
            ackVec[retireSlot.port] = 1'b1;
        end
    end

    // Fixed-priority arbitration cpu > l0 > l1 > spr among ports that request, have
    // nothing in flight, and are not being acked this cycle. Reset blocks all grants
    // so the RAM sees no access while reset is held.
    always_comb begin
        strobeVec  = {spr_strobe_i, l1_strobe_i, l0_strobe_i, cpu_strobe_i};
        eligible   = strobeVec & ~pending_q & ~ackVec & {4{~rst}};
        grantValid = 1'b0;
        grantPort  = PORT_CPU;
        grantVec   = 4'b0000;
        if (eligible[PORT_CPU]) begin
            grantValid = 1'b1;
            grantPort  = PORT_CPU;
        end else if (eligible[PORT_L0]) begin
            grantValid = 1'b1;
            grantPort  = PORT_L0;
        end else if (eligible[PORT_L1]) begin
            grantValid = 1'b1;
            grantPort  = PORT_L1;
        end else if (eligible[PORT_SPR]) begin
            grantValid = 1'b1;
            grantPort  = PORT_SPR;
        end
        if (grantValid) begin
            grantVec[grantPort] = 1'b1;
        end
    end

    // Drive the RAM straight from the grant and build the slot entering the pipeline.
    // Reads enable all byte lanes; only a CPU write uses the CPU byte enables.
    always_comb begin
        vram_en_o        = grantValid;
        vram_addr_o      = '0;
        vram_wrdata_o    = 32'h0;
        vram_wrbytesel_o = 4'h0;
        vram_write_o     = 1'b0;
        issueSlot        = '0;
        if (grantValid) begin
            vram_wrbytesel_o = 4'hF;
            issueSlot.valid  = 1'b1;
            issueSlot.port   = grantPort;
            case (grantPort)
                PORT_CPU: begin
                    vram_addr_o = cpu_addr_i;
                    if (cpu_write_i) begin
                        vram_write_o      = 1'b1;
                        vram_wrdata_o     = cpu_wrdata_i;
                        vram_wrbytesel_o  = cpu_wrbytesel_i;
                        issueSlot.isWrite = 1'b1;
                    end
                end
                PORT_L0:  vram_addr_o = l0_addr_i;
                PORT_L1:  vram_addr_o = l1_addr_i;
                default:  vram_addr_o = spr_addr_i;
            endcase
        end
    end

    // Pending bookkeeping and the read-data holding registers. A CPU write ack leaves
    // the CPU read data untouched; any display ack refreshes the broadcast bus.
    always_comb begin
        pending_d   = (pending_q & ~ackVec) | grantVec;
        cpuRdData_d = cpuRdData_q;
        busRdData_d = busRdData_q;
        if (ackVec[PORT_CPU] && !retireSlot.isWrite) begin
            cpuRdData_d = vram_rddata_i;
        end
        if (ackVec[PORT_L0] || ackVec[PORT_L1] || ackVec[PORT_SPR]) begin
            busRdData_d = vram_rddata_i;
        end
    end

    assign cpu_ack_o    = ackVec[PORT_CPU];
    assign l0_ack_o     = ackVec[PORT_L0];
    assign l1_ack_o     = ackVec[PORT_L1];
    assign spr_ack_o    = ackVec[PORT_SPR];
    assign cpu_rddata_o = cpuRdData_d;
    assign bus_rddata_o = busRdData_d;

    // Shift the in-flight slots one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= issueSlot;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Register pending bits and the held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 4'b0000;
            cpuRdData_q <= 32'h0;
            busRdData_q <= 32'h0;
        end else begin
            pending_q   <= pending_d;
            cpuRdData_q <= cpuRdData_d;
            busRdData_q <= busRdData_d;
        end
    end

endmodule

// File: tb/tb_vram_bus_responder.sv
// tb_vram_bus_responder
// Directed bench for vram_bus_responder with a behavioural VRAM model, simple
// masters that drop strobe in their ack cycle, and a scoreboard of expected acks
// (port, data, cycle) compared as the acks appear.
module tb_vram_bus_responder;

    localparam int AW  = 15;
    localparam int LAT = 2;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wrdata = 32'h0;
    logic [3:0]    cpu_wrbytesel = 4'h0;
    logic          cpu_write = 1'b0;
    logic          cpu_strobe;
    logic [31:0]   cpu_rddata;
    logic          cpu_ack;
    logic [AW-1:0] l0_addr = '0;
    logic [AW-1:0] l1_addr = '0;
    logic [AW-1:0] spr_addr = '0;
    logic          l0_strobe, l1_strobe, spr_strobe;
    logic          l0_ack, l1_ack, spr_ack;
    logic [31:0]   bus_rddata;
    logic [AW-1:0] vram_addr;
    logic [31:0]   vram_wrdata;
    logic [3:0]    vram_wrbytesel;
    logic          vram_write;
    logic          vram_en;
    logic [31:0]   vram_rddata;

    logic          cpuReq = 1'b0, l0Req = 1'b0, l1Req = 1'b0, sprReq = 1'b0;
    logic          sprHold = 1'b0;

    logic [31:0]   mem [0:63];
    logic [31:0]   rdPipe [LAT];

    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    exp_t          sbq [$];

    // Masters drop strobe combinationally in their own ack cycle.
    assign cpu_strobe = cpuReq & ~cpu_ack;
    assign l0_strobe  = l0Req  & ~l0_ack;
    assign l1_strobe  = l1Req  & ~l1_ack;
    assign spr_strobe = sprReq & ~spr_ack;
    assign vram_rddata = rdPipe[LAT-1];

    vram_bus_responder #(.ADDR_W(AW), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr_i(cpu_addr), .cpu_wrdata_i(cpu_wrdata), .cpu_wrbytesel_i(cpu_wrbytesel),
        .cpu_write_i(cpu_write), .cpu_strobe_i(cpu_strobe),
        .cpu_rddata_o(cpu_rddata), .cpu_ack_o(cpu_ack),
        .l0_addr_i(l0_addr), .l0_strobe_i(l0_strobe), .l0_ack_o(l0_ack),
        .l1_addr_i(l1_addr), .l1_strobe_i(l1_strobe), .l1_ack_o(l1_ack),
        .spr_addr_i(spr_addr), .spr_strobe_i(spr_strobe), .spr_ack_o(spr_ack),
        .bus_rddata_o(bus_rddata),
        .vram_addr_o(vram_addr), .vram_wrdata_o(vram_wrdata), .vram_wrbytesel_o(vram_wrbytesel),
        .vram_write_o(vram_write), .vram_en_o(vram_en), .vram_rddata_i(vram_rddata)
    );

    always #5 clk = ~clk;

    // Cycle counter: value N holds between posedge N and posedge N+1.
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: read-before-write, read data appears LAT cycles after the enable.
    always @(posedge clk) begin
        rdPipe[0] <= vram_en ? mem[vram_addr[5:0]] : 32'h0;
        for (int k = 1; k < LAT; k++) rdPipe[k] <= rdPipe[k-1];
        if (vram_en && vram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (vram_wrbytesel[b]) mem[vram_addr[5:0]][8*b +: 8] = vram_wrdata[8*b +: 8];
            end
        end
    end

    // One-shot masters release their request once they have sampled ack.
    always @(negedge clk) begin
        if (cpu_ack) cpuReq = 1'b0;
        if (l0_ack)  l0Req  = 1'b0;
        if (l1_ack)  l1Req  = 1'b0;
        if (spr_ack && !sprHold) sprReq = 1'b0;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest expectation in port, data and cycle.
    always @(negedge clk) begin
        logic [3:0] ackV;
        logic [1:0] port;
        exp_t       e;
        if (!rst) begin
            ackV = {spr_ack, l1_ack, l0_ack, cpu_ack};
            if (ackV != 4'b0000) begin
                checkVal("singleAck", 32'($countones(ackV)), 32'd1);
                port = cpu_ack ? 2'd0 : l0_ack ? 2'd1 : l1_ack ? 2'd2 : 2'd3;
                if (sbq.size() == 0) begin
                    checkVal("unexpectedAck", {28'h0, ackV}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    checkVal("ackPort", {30'h0, port}, {30'h0, e.port});
                    checkVal("ackCycle", cyc, e.cyc);
                    checkVal("ackData", (port == 2'd0) ? cpu_rddata : bus_rddata, e.data);
                end
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [1:0] port, input logic [31:0] data, input int at);
        sbq.push_back('{port: port, data: data, cyc: at});
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkVal("drainTimeout", sbq.size(), 32'd0);
        sbq.delete();
        applyStimulus();
    endtask

    task automatic checkOutput(input string tag, input logic en, input logic [AW-1:0] addr,
                               input logic wr, input logic [3:0] sel);
        checkVal({tag, ".en"}, {31'h0, vram_en}, {31'h0, en});
        if (en) begin
            checkVal({tag, ".addr"}, {17'h0, vram_addr}, {17'h0, addr});
            checkVal({tag, ".write"}, {31'h0, vram_write}, {31'h0, wr});
            checkVal({tag, ".sel"}, {28'h0, vram_wrbytesel}, {28'h0, sel});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".acks"}, {28'h0, spr_ack, l1_ack, l0_ack, cpu_ack}, 32'h0);
        checkVal({tag, ".en"}, {31'h0, vram_en}, 32'h0);
        checkVal({tag, ".write"}, {31'h0, vram_write}, 32'h0);
        checkVal({tag, ".addr"}, {17'h0, vram_addr}, 32'h0);
        checkVal({tag, ".wrdata"}, vram_wrdata, 32'h0);
        checkVal({tag, ".sel"}, {28'h0, vram_wrbytesel}, 32'h0);
        checkVal({tag, ".busRd"}, bus_rddata, 32'h0);
        checkVal({tag, ".cpuRd"}, cpu_rddata, 32'h0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[16] = 32'hDEADBEEF;
        mem[5]  = 32'hAAAAAAAA;

        // Reset state
        repeat (3) applyStimulus();
        checkResetOutputs("reset");
        rst = 1'b0;
        applyStimulus();

        // 1: single l0 read
        n = cyc;
        l0Req = 1'b1; l0_addr = 15'h0010;
        #1;
        checkOutput("t1.issue", 1'b1, 15'h0010, 1'b0, 4'hF);
        pushExp(2'd1, 32'hDEADBEEF, n + LAT);
        waitDrain(20);

        // 2: all four requests at once, served cpu, l0, l1, spr on consecutive cycles
        n = cyc;
        cpu_write = 1'b0;
        cpu_addr = 15'h0020; l0_addr = 15'h0021; l1_addr = 15'h0022; spr_addr = 15'h0023;
        cpuReq = 1'b1; l0Req = 1'b1; l1Req = 1'b1; sprReq = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            pushExp(2'(i), 32'h1000_0020 + i, n + i + LAT);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2.grant%0d", i), 1'b1, AW'(32'h20 + i), 1'b0, 4'hF);
            applyStimulus();
        end
        checkOutput("t2.idle", 1'b0, '0, 1'b0, 4'h0);
        waitDrain(20);

        // 3: CPU byte-masked write then read-back
        n = cyc;
        cpu_addr = 15'h0005; cpu_write = 1'b1;
        cpu_wrdata = 32'h11223344; cpu_wrbytesel = 4'b0101;
        cpuReq = 1'b1;
        #1;
        checkOutput("t3.write", 1'b1, 15'h0005, 1'b1, 4'b0101);
        checkVal("t3.wrdata", vram_wrdata, 32'h11223344);
        pushExp(2'd0, 32'h1000_0020, n + LAT);
        waitDrain(20);
        n = cyc;
        cpu_write = 1'b0; cpuReq = 1'b1;
        #1;
        checkOutput("t3.read", 1'b1, 15'h0005, 1'b0, 4'hF);
        pushExp(2'd0, 32'hAA22AA44, n + LAT);
        waitDrain(20);

        // 4: spr holding strobe, one access per LAT+1 cycles
        n = cyc;
        spr_addr = 15'h0030; sprHold = 1'b1; sprReq = 1'b1;
        for (int i = 0; i < 4; i++) pushExp(2'd3, 32'h1000_0030, n + LAT + i * (LAT + 1));
        #1;
        checkOutput("t4.first", 1'b1, 15'h0030, 1'b0, 4'hF);
        applyStimulus();
        checkOutput("t4.blocked1", 1'b0, '0, 1'b0, 4'h0);
        applyStimulus();
        checkOutput("t4.blocked2", 1'b0, '0, 1'b0, 4'h0);
        applyStimulus();
        checkOutput("t4.second", 1'b1, 15'h0030, 1'b0, 4'hF);
        while (cyc < n + LAT + 3 * (LAT + 1)) applyStimulus();
        sprHold = 1'b0; sprReq = 1'b0;
        waitDrain(30);

        // 5: reset while an l1 read is in flight
        n = cyc;
        l1_addr = 15'h0031; l1Req = 1'b1;
        #1;
        checkOutput("t5.issue", 1'b1, 15'h0031, 1'b0, 4'hF);
        applyStimulus();
        rst = 1'b1; l1Req = 1'b0;
        #1;
        checkResetOutputs("t5.inReset");
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        repeat (5) applyStimulus();
        checkResetOutputs("t5.after");
        n = cyc;
        l1Req = 1'b1;
        #1;
        pushExp(2'd2, 32'h1000_0031, n + LAT);
        waitDrain(20);

        // 6: l0 strobe dropped after issue still gets its ack
        n = cyc;
        l0_addr = 15'h0032; l0Req = 1'b1;
        #1;
        pushExp(2'd1, 32'h1000_0032, n + LAT);
        applyStimulus();
        l0Req = 1'b0;
        #1;
        checkOutput("t6.dropped", 1'b0, '0, 1'b0, 4'h0);
        while (cyc < n + LAT) applyStimulus();
        applyStimulus();
        n = cyc;
        l0Req = 1'b1;
        #1;
        checkOutput("t6.reissue", 1'b1, 15'h0032, 1'b0, 4'hF);
        pushExp(2'd1, 32'h1000_0032, n + LAT);
        waitDrain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
